// File: rtl/philv_pkg.sv
// ============================================================================
// Module  : philv_pkg
// Shared state encodings, RV32I opcodes, ALU codes and datapath mux selects.
// Revision: 1.0
// ============================================================================
`default_nettype none

package philv_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic       PC_SRC_ALU = 1'b0;
  localparam logic       PC_SRC_TGT = 1'b1;
  localparam logic       ADDR_PC    = 1'b0;
  localparam logic       ADDR_ALU   = 1'b1;
  localparam logic [1:0] WB_ALU     = 2'b00;
  localparam logic [1:0] WB_MEM     = 2'b01;
  localparam logic [1:0] WB_PC      = 2'b10;
  localparam logic [1:0] A_RS1      = 2'b00;
  localparam logic [1:0] A_PC       = 2'b01;
  localparam logic [1:0] A_ZERO     = 2'b10;
  localparam logic [1:0] B_RS2      = 2'b00;
  localparam logic [1:0] B_IMM      = 2'b01;
  localparam logic [1:0] B_FOUR     = 2'b10;

  // Only word loads/stores and BEQ/BNE are implemented in this subset.
  function automatic logic f3_legal(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_LOAD, OP_STORE: return (f3 == 3'b010);
      OP_BRANCH:         return (f3 == 3'b000) || (f3 == 3'b001);
      default:           return 1'b1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/philv_alu_decode.sv
// ============================================================================
// Module  : philv_alu_decode
// Maps {opcode, funct3, funct7[5]} to the ALU operation code.
// Revision: 1.0
// ============================================================================
`default_nettype none

module philv_alu_decode
  import philv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (opcode)
      OP_R, OP_I: begin
        case (funct3)
          3'b000:  alu_op = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLTU;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      OP_BRANCH: alu_op = ALU_SUB;
      default:   alu_op = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/philv_mc_controller.sv
// ============================================================================
// Module  : philv_mc_controller
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for an RV32I subset.
// Define PHILV_MEM_WAIT_EN to stall FETCH and MEM until mem_ready.
// Revision: 1.0
// ============================================================================
`default_nettype none

module philv_mc_controller
  import philv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [XLEN-1:0]  instr,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             pc_src,
  output logic             ir_we,
  output logic             mem_re,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_op,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             retire,
  output logic [CNT_W-1:0] instret
);

  state_t           r_state;
  logic             r_illegal;
  logic [CNT_W-1:0] r_instret;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_op_ok;
  logic       w_f3_ok;
  logic       w_taken;
  logic       w_ready;
  logic [3:0] w_dec_op;
  logic       w_unused;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_f3_ok  = f3_legal(w_opcode, w_funct3);
  assign w_taken  = ((w_funct3 == 3'b000) &&  alu_zero) ||
                    ((w_funct3 == 3'b001) && !alu_zero);
  assign w_op_ok  = (w_opcode == OP_R)      || (w_opcode == OP_I)     ||
                    (w_opcode == OP_LOAD)   || (w_opcode == OP_STORE) ||
                    (w_opcode == OP_BRANCH) || (w_opcode == OP_JAL)   ||
                    (w_opcode == OP_LUI);

`ifdef PHILV_MEM_WAIT_EN
  assign w_ready  = mem_ready;
  assign w_unused = ^{instr[XLEN-1:31], instr[29:15], instr[11:7]};
`else
  assign w_ready  = 1'b1;
  assign w_unused = ^{instr[XLEN-1:31], instr[29:15], instr[11:7], mem_ready};
`endif

  philv_alu_decode u_alu_decode (
    .opcode   (w_opcode),
    .funct3   (w_funct3),
    .funct7b5 (instr[30]),
    .alu_op   (w_dec_op)
  );

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
      r_instret <= '0;
    end else begin
      if (retire) r_instret <= r_instret + CNT_W'(1);
      case (r_state)
        S_FETCH:  if (w_ready) r_state <= S_DECODE;
        S_DECODE: begin
          if (w_op_ok) begin
            r_state <= S_EXEC;
          end else begin
            r_state   <= S_HALT;
            r_illegal <= 1'b1;
          end
        end
        S_EXEC: begin
          if (!w_f3_ok) begin
            r_state   <= S_HALT;
            r_illegal <= 1'b1;
          end else if (w_opcode == OP_LOAD || w_opcode == OP_STORE) begin
            r_state <= S_MEM;
          end else if (w_opcode == OP_BRANCH || w_opcode == OP_JAL) begin
            r_state <= S_FETCH;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM:    if (w_ready) r_state <= (w_opcode == OP_LOAD) ? S_WB : S_FETCH;
        S_WB:     r_state <= S_FETCH;
        default:  r_state <= S_HALT;
      endcase
    end
  end

  // Strobes are gated by rstb so a reset mid-instruction commits nothing.
  always_comb begin
    pc_we        = 1'b0;
    pc_src       = PC_SRC_ALU;
    ir_we        = 1'b0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = ADDR_PC;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
    alu_src_a    = A_RS1;
    alu_src_b    = B_RS2;
    alu_op       = ALU_ADD;
    retire       = 1'b0;
    if (rstb) begin
      case (r_state)
        S_FETCH: begin
          mem_re    = 1'b1;
          alu_src_a = A_PC;
          alu_src_b = B_FOUR;
          ir_we     = w_ready;
          pc_we     = w_ready;
        end
        S_EXEC: begin
          if (w_f3_ok) begin
            alu_op = w_dec_op;
            case (w_opcode)
              OP_I, OP_LOAD, OP_STORE: alu_src_b = B_IMM;
              OP_LUI: begin
                alu_src_a = A_ZERO;
                alu_src_b = B_IMM;
              end
              OP_BRANCH: begin
                pc_we  = w_taken;
                pc_src = w_taken ? PC_SRC_TGT : PC_SRC_ALU;
                retire = 1'b1;
              end
              OP_JAL: begin
                pc_we  = 1'b1;
                pc_src = PC_SRC_TGT;
                reg_we = 1'b1;
                wb_sel = WB_PC;
                retire = 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_MEM: begin
          mem_addr_sel = ADDR_ALU;
          if (w_opcode == OP_LOAD) begin
            mem_re = 1'b1;
          end else begin
            mem_we = 1'b1;
            retire = w_ready;
          end
        end
        S_WB: begin
          reg_we = 1'b1;
          wb_sel = (w_opcode == OP_LOAD) ? WB_MEM : WB_ALU;
          retire = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state   = r_state;
  assign illegal = r_illegal;
  assign instret = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_philv_mc_controller.sv
// ============================================================================
// Module  : tb_philv_mc_controller
// Self-checking bench for philv_mc_controller against an instruction-level model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_philv_mc_controller;

  localparam int CNT_W = 4;
`ifdef PHILV_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rstb = 1'b0;
  logic [31:0]      instr = '0;
  logic             alu_zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             pc_we, pc_src, ir_we, mem_re, mem_we, mem_addr_sel, reg_we;
  logic [1:0]       wb_sel, alu_src_a, alu_src_b;
  logic [3:0]       alu_op;
  logic [2:0]       state;
  logic             illegal, retire;
  logic [CNT_W-1:0] instret;

  philv_mc_controller #(.XLEN(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstb(rstb), .instr(instr), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .reg_we(reg_we), .wb_sel(wb_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state), .illegal(illegal),
    .retire(retire), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_we, pc_src, ir_we, mem_re, mem_we, mem_addr_sel, reg_we;
    logic [1:0] wb_sel, asel, bsel;
    logic [3:0] op;
    logic [2:0] st;
    logic       ill, ret;
  } ov_t;

  typedef enum int {PF, PD, PE, PM, PW, PH} ph_t;
  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_JAL = 5, C_LUI = 6;
  localparam int C_BADOP = 7, C_BADF3 = 8;

  int               n_chk = 0;
  int               n_fail = 0;
  bit               m_ill = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;
  ov_t              q_obs[$], q_exp[$], q_msk[$];
  logic [CNT_W-1:0] q_cobs[$], q_cexp[$];

  function automatic int iclass(input logic [31:0] ins);
    logic [2:0] f3;
    f3 = ins[14:12];
    case (ins[6:0])
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b0000011: return (f3 == 3'b010) ? C_LD : C_BADF3;
      7'b0100011: return (f3 == 3'b010) ? C_ST : C_BADF3;
      7'b1100011: return (f3 <= 3'b001) ? C_BR : C_BADF3;
      7'b1101111: return C_JAL;
      7'b0110111: return C_LUI;
      default:    return C_BADOP;
    endcase
  endfunction

  function automatic logic [3:0] ref_op(input int c, input logic [31:0] ins);
    logic [2:0] f3;
    logic       alt;
    f3  = ins[14:12];
    alt = ins[30];
    if (c == C_BR) return 4'd1;
    if (c != C_R && c != C_I) return 4'd0;
    case (f3)
      3'd0:    return (c == C_R && alt) ? 4'd1 : 4'd0;
      3'd1:    return 4'd2;
      3'd2:    return 4'd3;
      3'd3:    return 4'd4;
      3'd4:    return 4'd5;
      3'd5:    return alt ? 4'd7 : 4'd6;
      3'd6:    return 4'd8;
      default: return 4'd9;
    endcase
  endfunction

  function automatic logic [2:0] st_code(input ph_t ph);
    case (ph)
      PF: return 3'd0;
      PD: return 3'd1;
      PE: return 3'd2;
      PM: return 3'd3;
      PW: return 3'd4;
      default: return 3'd7;
    endcase
  endfunction

  // Expected outputs per phase; mask bits mark the fields the phase defines.
  function automatic void exp_out(input ph_t ph, input int c, input logic [31:0] ins,
                                  input bit z, input bit rdy, input bit ab,
                                  output ov_t e, output ov_t m);
    bit go, tk;
    e = '0; m = '0;
    m.pc_we = 1; m.ir_we = 1; m.mem_re = 1; m.mem_we = 1; m.reg_we = 1;
    m.st = 3'b111; m.ill = 1; m.ret = 1;
    e.st  = st_code(ph);
    e.ill = m_ill | (ph == PH);
    go    = !WAIT_EN || rdy;
    if (!ab) begin
      case (ph)
        PF: begin
          e.mem_re = 1; e.ir_we = go; e.pc_we = go; e.asel = 2'b01; e.bsel = 2'b10;
          m.asel = '1; m.bsel = '1; m.op = '1; m.pc_src = 1; m.mem_addr_sel = 1;
        end
        PE: begin
          case (c)
            C_R, C_I, C_LD, C_ST, C_LUI: begin
              e.asel = (c == C_LUI) ? 2'b10 : 2'b00;
              e.bsel = (c == C_R) ? 2'b00 : 2'b01;
              e.op = ref_op(c, ins);
              m.asel = '1; m.bsel = '1; m.op = '1;
            end
            C_BR: begin
              tk = (ins[14:12] == 3'b000 && z) || (ins[14:12] == 3'b001 && !z);
              e.op = ref_op(c, ins); e.pc_we = tk; e.pc_src = tk; e.ret = 1;
              m.asel = '1; m.bsel = '1; m.op = '1; m.pc_src = 1;
            end
            C_JAL: begin
              e.pc_we = 1; e.pc_src = 1; e.reg_we = 1; e.wb_sel = 2'b10; e.ret = 1;
              m.pc_src = 1; m.wb_sel = '1;
            end
            default: ;
          endcase
        end
        PM: begin
          e.mem_addr_sel = 1; m.mem_addr_sel = 1;
          if (c == C_LD) e.mem_re = 1;
          else begin e.mem_we = 1; e.ret = go; end
        end
        PW: begin
          e.reg_we = 1; e.wb_sel = (c == C_LD) ? 2'b01 : 2'b00; e.ret = 1; m.wb_sel = '1;
        end
        default: ;
      endcase
    end
  endfunction

  // Drives one instruction through its phase list and records observed/expected cycles.
  task automatic run_instr(input logic [31:0] ins, input int fwait, input int mwait,
                           input int zmode, input int hcyc, input int abort_ph);
    int  c, idx, cnt;
    bit  rdy, ab;
    ph_t ph;
    ph_t seq[$];
    ov_t o, e, m;
    c = iclass(ins);
    seq = {PF, PD};
    case (c)
      C_R, C_I, C_LUI: begin seq.push_back(PE); seq.push_back(PW); end
      C_LD:            begin seq.push_back(PE); seq.push_back(PM); seq.push_back(PW); end
      C_ST:            begin seq.push_back(PE); seq.push_back(PM); end
      C_BR, C_JAL:     seq.push_back(PE);
      C_BADOP:         seq.push_back(PH);
      default:         begin seq.push_back(PE); seq.push_back(PH); end
    endcase
    q_obs.delete(); q_exp.delete(); q_msk.delete(); q_cobs.delete(); q_cexp.delete();
    idx = 0; cnt = 0;
    while (idx < seq.size()) begin
      ph = seq[idx];
      instr    = (ph == PF) ? $urandom : ins;
      alu_zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : zmode[0];
      if (ph == PF)      rdy = (cnt >= fwait);
      else if (ph == PM) rdy = (cnt >= mwait);
      else               rdy = 1'($urandom_range(0, 1));
      mem_ready = rdy;
      ab   = (int'(ph) == abort_ph);
      rstb = !ab;
      @(negedge clk);
      o = {pc_we, pc_src, ir_we, mem_re, mem_we, mem_addr_sel, reg_we, wb_sel,
           alu_src_a, alu_src_b, alu_op, state, illegal, retire};
      exp_out(ph, c, ins, alu_zero, rdy, ab, e, m);
      q_obs.push_back(o); q_exp.push_back(e); q_msk.push_back(m);
      q_cobs.push_back(instret); q_cexp.push_back(m_cnt);
      if (!ab && e.ret) m_cnt = m_cnt + 1'b1;
      if (ph == PH) m_ill = 1'b1;
      @(posedge clk); #1;
      if (ab) begin
        rstb = 1'b1; m_cnt = '0; m_ill = 1'b0;
        break;
      end
      if (ph == PH) begin
        cnt++;
        if (cnt >= hcyc) break;
      end else if (WAIT_EN && (ph == PF || ph == PM) && !rdy) begin
        cnt++;
      end else begin
        idx++; cnt = 0;
      end
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0; instr = $urandom; alu_zero = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({pc_we, ir_we, mem_re, mem_we, reg_we, retire} !== 6'd0) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 000000",
                         {pc_we, ir_we, mem_re, mem_we, reg_we, retire});
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if (state !== 3'd0 || illegal !== 1'b0 || instret !== '0 || mem_re !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: got st=%0d ill=%b instret=%0d mem_re=%b expected 0/0/0/0",
                         state, illegal, instret, mem_re);
    end
    @(posedge clk); #1;
    rstb = 1'b1; m_cnt = '0; m_ill = 1'b0;
  endtask

  task automatic test_addi();
    run_instr(32'h00500193, 0, 0, -1, 0, -1);
    for (int i = 0; i < q_obs.size(); i++) begin
      n_chk++;
      if ((((q_obs[i] ^ q_exp[i]) & q_msk[i]) !== 22'd0) || (q_cobs[i] !== q_cexp[i])) begin
        n_fail++; $display("FAIL addi cyc%0d: got %h/%0d expected %h/%0d mask %h",
                           i, q_obs[i], q_cobs[i], q_exp[i], q_cexp[i], q_msk[i]);
      end
    end
    n_chk++;
    if (q_obs.size() !== 4 || instret !== 4'd1) begin
      n_fail++; $display("FAIL addi_latency: got %0d cycles instret %0d expected 4 cycles instret 1",
                         q_obs.size(), instret);
    end
  endtask

  task automatic test_sub();
    run_instr(32'h40208033, 0, 0, -1, 0, -1);
    for (int i = 0; i < q_obs.size(); i++) begin
      n_chk++;
      if ((((q_obs[i] ^ q_exp[i]) & q_msk[i]) !== 22'd0) || (q_cobs[i] !== q_cexp[i])) begin
        n_fail++; $display("FAIL sub cyc%0d: got %h/%0d expected %h/%0d mask %h",
                           i, q_obs[i], q_cobs[i], q_exp[i], q_cexp[i], q_msk[i]);
      end
    end
    n_chk++;
    if (q_obs.size() !== 4 || q_obs[2].op !== 4'd1) begin
      n_fail++; $display("FAIL sub_op: got %0d cycles op %0d expected 4 cycles op 1",
                         q_obs.size(), q_obs[2].op);
    end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      run_instr(32'h00208463, 0, 0, z, 0, -1);
      for (int i = 0; i < q_obs.size(); i++) begin
        n_chk++;
        if ((((q_obs[i] ^ q_exp[i]) & q_msk[i]) !== 22'd0) || (q_cobs[i] !== q_cexp[i])) begin
          n_fail++; $display("FAIL beq z=%0d cyc%0d: got %h/%0d expected %h/%0d mask %h",
                             z, i, q_obs[i], q_cobs[i], q_exp[i], q_cexp[i], q_msk[i]);
        end
      end
      n_chk++;
      if (q_obs.size() !== 3 || q_obs[2].pc_we !== z[0]) begin
        n_fail++; $display("FAIL beq_taken z=%0d: got %0d cycles pc_we %b expected 3 cycles pc_we %b",
                           z, q_obs.size(), q_obs[2].pc_we, z[0]);
      end
    end
  endtask

  task automatic test_lw();
    run_instr(32'h0000a183, 0, 2, -1, 0, -1);
    for (int i = 0; i < q_obs.size(); i++) begin
      n_chk++;
      if ((((q_obs[i] ^ q_exp[i]) & q_msk[i]) !== 22'd0) || (q_cobs[i] !== q_cexp[i])) begin
        n_fail++; $display("FAIL lw cyc%0d: got %h/%0d expected %h/%0d mask %h",
                           i, q_obs[i], q_cobs[i], q_exp[i], q_cexp[i], q_msk[i]);
      end
    end
    n_chk++;
    if (q_obs.size() !== (WAIT_EN ? 7 : 5) || q_obs[q_obs.size()-1].wb_sel !== 2'b01) begin
      n_fail++; $display("FAIL lw_latency: got %0d cycles wb_sel %b expected %0d cycles wb_sel 01",
                         q_obs.size(), q_obs[q_obs.size()-1].wb_sel, WAIT_EN ? 7 : 5);
    end
  endtask

  task automatic test_halt();
    logic [31:0] bad[2];
    bad[0] = 32'h00000000;
    bad[1] = 32'h0020c463;
    for (int k = 0; k < 2; k++) begin
      run_instr(bad[k], 0, 0, -1, 10, -1);
      for (int i = 0; i < q_obs.size(); i++) begin
        n_chk++;
        if ((((q_obs[i] ^ q_exp[i]) & q_msk[i]) !== 22'd0) || (q_cobs[i] !== q_cexp[i])) begin
          n_fail++; $display("FAIL halt%0d cyc%0d: got %h/%0d expected %h/%0d mask %h",
                             k, i, q_obs[i], q_cobs[i], q_exp[i], q_cexp[i], q_msk[i]);
        end
      end
      rstb = 1'b0; instr = $urandom; mem_ready = 1'b1;
      @(negedge clk);
      n_chk++;
      if ({pc_we, ir_we, mem_re, mem_we, reg_we, retire} !== 6'd0 || illegal !== 1'b1) begin
        n_fail++; $display("FAIL halt%0d_rstcycle: got strobes %b ill %b expected 000000 ill 1",
                           k, {pc_we, ir_we, mem_re, mem_we, reg_we, retire}, illegal);
      end
      @(posedge clk); #1;
      rstb = 1'b1; m_cnt = '0; m_ill = 1'b0;
      n_chk++;
      if (state !== 3'd0 || illegal !== 1'b0 || instret !== '0) begin
        n_fail++; $display("FAIL halt%0d_release: got st=%0d ill=%b instret=%0d expected 0/0/0",
                           k, state, illegal, instret);
      end
      run_instr(32'h00500193, 0, 0, -1, 0, -1);
      for (int i = 0; i < q_obs.size(); i++) begin
        n_chk++;
        if ((((q_obs[i] ^ q_exp[i]) & q_msk[i]) !== 22'd0) || (q_cobs[i] !== q_cexp[i])) begin
          n_fail++; $display("FAIL post_halt%0d cyc%0d: got %h/%0d expected %h/%0d mask %h",
                             k, i, q_obs[i], q_cobs[i], q_exp[i], q_cexp[i], q_msk[i]);
        end
      end
    end
  endtask

  task automatic test_abort_store();
    run_instr(32'h0020a023, 0, 0, -1, 0, int'(PM));
    for (int i = 0; i < q_obs.size(); i++) begin
      n_chk++;
      if ((((q_obs[i] ^ q_exp[i]) & q_msk[i]) !== 22'd0) || (q_cobs[i] !== q_cexp[i])) begin
        n_fail++; $display("FAIL abort_sw cyc%0d: got %h/%0d expected %h/%0d mask %h",
                           i, q_obs[i], q_cobs[i], q_exp[i], q_cexp[i], q_msk[i]);
      end
    end
    n_chk++;
    if (state !== 3'd0 || instret !== '0 || q_obs[3].mem_we !== 1'b0 || q_cobs[3] !== 4'd1) begin
      n_fail++; $display("FAIL abort_sw_after: got st=%0d instret=%0d mem_we=%b cnt_in_mem=%0d expected 0/0/0/1",
                         state, instret, q_obs[3].mem_we, q_cobs[3]);
    end
  endtask

  task automatic test_random();
    logic [31:0] r, ins;
    int          c;
    for (int n = 0; n < 80; n++) begin
      r = $urandom;
      c = $urandom_range(0, 6);
      case (c)
        C_R:     ins = {1'b0, r[30], 5'b0, r[24:7], 7'b0110011};
        C_I:     ins = {r[31:7], 7'b0010011};
        C_LD:    ins = {r[31:15], 3'b010, r[11:7], 7'b0000011};
        C_ST:    ins = {r[31:15], 3'b010, r[11:7], 7'b0100011};
        C_BR:    ins = {r[31:15], 2'b00, r[12], r[11:7], 7'b1100011};
        C_JAL:   ins = {r[31:7], 7'b1101111};
        default: ins = {r[31:7], 7'b0110111};
      endcase
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), -1, 0, -1);
      for (int i = 0; i < q_obs.size(); i++) begin
        n_chk++;
        if ((((q_obs[i] ^ q_exp[i]) & q_msk[i]) !== 22'd0) || (q_cobs[i] !== q_cexp[i])) begin
          n_fail++; $display("FAIL random #%0d ins=%h cyc%0d: got %h/%0d expected %h/%0d mask %h",
                             n, ins, i, q_obs[i], q_cobs[i], q_exp[i], q_cexp[i], q_msk[i]);
        end
      end
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_addi();
    test_sub();
    test_beq();
    test_lw();
    test_halt();
    test_abort_store();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
